// File: rtl/oam_dma.sv
// OAM DMA sequencer: copies LENGTH bytes from page src_reg to DST_BASE and
// owns the shared memory bus while doing so.
module oam_dma #(
    parameter logic [15:0] REG_ADDR = 16'hFF46,
    parameter logic [15:0] DST_BASE = 16'hFE00,
    parameter int unsigned LENGTH   = 160,
    parameter int unsigned CNTBITS  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_w,
    input  logic        cpu_write_enable,
    output logic [7:0]  cpu_data_r,
    output logic        reg_active,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_w,
    output logic        bus_write_enable,
    input  logic [7:0]  bus_data_r,
    output logic        dma_active
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [CNTBITS-1:0] LAST = CNTBITS'(LENGTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CNTBITS-1:0] counter_q, counter_d;
    logic [7:0]         src_q, src_d;
    logic [7:0]         latch_q, latch_d;
    logic               reg_hit;
    logic               reg_wr;
    logic [7:0]         src_page;

    assign reg_hit  = (cpu_addr == REG_ADDR);
    assign reg_wr   = reg_hit && cpu_write_enable;
    // Echo/OAM/IO pages fold down into WRAM.
    assign src_page = (src_q < 8'hE0) ? src_q : src_q - 8'h20;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            src_q     <= 8'hFF;
            latch_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            src_q     <= src_d;
            latch_q   <= latch_d;
        end
    end

    // Next state; a register write in any state (re)starts from byte 0.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        latch_d   = latch_q;
        src_d     = src_q;
        case (state_q)
            IDLE:  state_d = IDLE;
            START: state_d = READ;
            READ: begin
                latch_d = bus_data_r;
                state_d = WRITE;
            end
            WRITE: begin
                if (counter_q == LAST) begin
                    state_d   = IDLE;
                    counter_d = '0;
                end else begin
                    state_d   = READ;
                    counter_d = counter_q + CNTBITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (reg_wr) begin
            src_d     = cpu_data_w;
            state_d   = START;
            counter_d = '0;
        end
    end

    // Bus mux: CPU owns the bus only while idle.
    always_comb begin
        bus_addr         = cpu_addr;
        bus_data_w       = cpu_data_w;
        bus_write_enable = cpu_write_enable && !reg_hit;
        case (state_q)
            START: begin
                bus_addr         = {src_page, 8'(counter_q)};
                bus_data_w       = latch_q;
                bus_write_enable = 1'b0;
            end
            READ: begin
                bus_addr         = {src_page, 8'(counter_q)};
                bus_data_w       = latch_q;
                bus_write_enable = 1'b0;
            end
            WRITE: begin
                bus_addr         = DST_BASE + 16'(counter_q);
                bus_data_w       = latch_q;
                bus_write_enable = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_data_r = reg_hit ? src_q : ((state_q == IDLE) ? bus_data_r : 8'hFF);
    assign reg_active = reg_hit && !cpu_write_enable;
    assign dma_active = (state_q != IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma against a flat memory and a byte-level copy model.
module tb_oam_dma;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_w;
    logic        cpu_write_enable;
    logic [7:0]  cpu_data_r;
    logic        reg_active;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_w;
    logic        bus_write_enable;
    logic [7:0]  bus_data_r;
    logic        dma_active;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    int checks   = 0;
    int failures = 0;

    oam_dma dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_addr         (cpu_addr),
        .cpu_data_w       (cpu_data_w),
        .cpu_write_enable (cpu_write_enable),
        .cpu_data_r       (cpu_data_r),
        .reg_active       (reg_active),
        .bus_addr         (bus_addr),
        .bus_data_w       (bus_data_w),
        .bus_write_enable (bus_write_enable),
        .bus_data_r       (bus_data_r),
        .dma_active       (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared memory: posedge write, negedge read.
    always @(posedge clk) if (bus_write_enable === 1'b1) mem[bus_addr] <= bus_data_w;
    always @(negedge clk) bus_data_r <= mem[bus_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic we, input logic rst);
        @(posedge clk);
        #1;
        cpu_addr         = a;
        cpu_data_w       = d;
        cpu_write_enable = we;
        reset            = rst;
        #1;
    endtask

    function automatic logic [7:0] eff_page(input logic [7:0] s);
        return (s >= 8'hE0) ? s - 8'h20 : s;
    endfunction

    task automatic fill(input logic [7:0] page, input bit pattern);
        logic [7:0] v;
        for (int i = 0; i < 160; i++) begin
            v = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
            step({page, 8'(i)}, v, 1'b1, 1'b0);
            ref_mem[{page, 8'(i)}] = v;
        end
    endtask

    task automatic oam_cmp(input string tag);
        int bad = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hFE00 + 16'(i)] !== ref_mem[16'hFE00 + 16'(i)]) bad++;
        check(tag, bad, 0);
    endtask

    // Runs one transfer; the expected schedule is START, then READ/WRITE pairs per byte.
    task automatic run_dma(input logic [7:0] src_in, input int restart_at, input logic [7:0] src2,
                           input int reset_at, input bit poke);
        logic [7:0]  src;
        logic [7:0]  page;
        logic [15:0] ea;
        logic        ew;
        int          n, m, j, base, bad;
        src  = src_in;
        page = eff_page(src);
        step(16'hFF46, src, 1'b1, 1'b0);
        check("trig_we", bus_write_enable, 0);
        step(16'h0000, 8'h00, 1'b0, 1'b0);
        n = 0; base = 0; bad = 0;
        while (dma_active === 1'b1 && n < 1000) begin
            m = n - base;
            if (m >= 1) begin
                j = (m - 1) / 2;
                if (m % 2 == 1) begin
                    ea = {page, 8'(j)};
                    ew = 1'b0;
                end else begin
                    ea = 16'hFE00 + 16'(j);
                    ew = 1'b1;
                end
                if (bus_addr !== ea || bus_write_enable !== ew) bad++;
                if (ew) begin
                    if (bus_data_w !== ref_mem[{page, 8'(j)}]) bad++;
                    ref_mem[ea] = ref_mem[{page, 8'(j)}];
                end
            end
            if (poke && n == 20) check("busy_rd", cpu_data_r, 8'hFF);
            if (poke && n == 30) begin
                check("busy_reg_rd", cpu_data_r, src);
                check("busy_reg_act", reg_active, 1);
            end
            if (n + 1 == restart_at)          step(16'hFF46, src2, 1'b1, 1'b0);
            else if (n + 1 == reset_at)       step(16'hFF46, 8'hC5, 1'b1, 1'b1);
            else if (poke && n + 1 == 10)     step(16'hC100, 8'h12, 1'b1, 1'b0);
            else if (poke && n + 1 == 20)     step(16'h8000, 8'h00, 1'b0, 1'b0);
            else if (poke && n + 1 == 30)     step(16'hFF46, 8'h00, 1'b0, 1'b0);
            else                              step(16'h0000, 8'h00, 1'b0, 1'b0);
            if (n == restart_at) begin
                base = n + 1;
                src  = src2;
                page = eff_page(src2);
            end
            n++;
        end
        check("timeout", (n < 1000), 1);
        if (reset_at >= 0) check("len_reset", n, reset_at + 1);
        else               check("len", n - base, 321);
        check("bus_seq", bad, 0);
    endtask

    initial begin
        logic [7:0] s;
        cpu_addr = 16'h0000; cpu_data_w = 8'h00; cpu_write_enable = 1'b0; reset = 1'b1;
        step(16'h0000, 8'h00, 1'b0, 1'b1);
        step(16'h0000, 8'h00, 1'b0, 1'b1);
        step(16'hFF46, 8'h00, 1'b0, 1'b0);
        check("rst_reg_rd", cpu_data_r, 8'hFF);
        check("rst_reg_act", reg_active, 1);
        check("rst_dma", dma_active, 0);
        check("rst_bus_addr", bus_addr, 16'hFF46);
        check("rst_bus_we", bus_write_enable, 0);
        step(16'hC100, 8'h99, 1'b1, 1'b0);
        check("idle_bus_addr", bus_addr, 16'hC100);
        check("idle_bus_dw", bus_data_w, 8'h99);
        check("idle_bus_we", bus_write_enable, 1);
        check("idle_reg_act", reg_active, 0);
        ref_mem[16'hC100] = 8'h99;

        fill(8'hC0, 1'b1);
        run_dma(8'hC0, -1, 8'h00, -1, 1'b1);
        oam_cmp("oam_c0");
        check("oam_fe05", mem[16'hFE05], 8'h05 ^ 8'h5A);
        check("c100_kept", mem[16'hC100], 8'h99);

        fill(8'hDE, 1'b0);
        run_dma(8'hFE, -1, 8'h00, -1, 1'b0);
        oam_cmp("oam_fe_remap");

        fill(8'hDF, 1'b0);
        run_dma(8'hDF, -1, 8'h00, -1, 1'b0);
        oam_cmp("oam_df");

        fill(8'hD0, 1'b0);
        run_dma(8'hC0, 50, 8'hD0, -1, 1'b0);
        oam_cmp("oam_restart");

        run_dma(8'hC0, -1, 8'h00, 100, 1'b0);
        oam_cmp("oam_partial");
        step(16'hFF46, 8'h00, 1'b0, 1'b0);
        check("post_rst_reg", cpu_data_r, 8'hFF);
        check("post_rst_dma", dma_active, 0);
        step(16'hFE00, 8'h77, 1'b1, 1'b0);
        check("post_rst_addr", bus_addr, 16'hFE00);
        check("post_rst_we", bus_write_enable, 1);
        check("post_rst_dw", bus_data_w, 8'h77);
        ref_mem[16'hFE00] = 8'h77;
        step(16'h0000, 8'h00, 1'b0, 1'b0);
        check("post_rst_mem", mem[16'hFE00], ref_mem[16'hFE00]);

        for (int t = 0; t < 3; t++) begin
            s = 8'($urandom_range(0, 255));
            fill(eff_page(s), 1'b0);
            run_dma(s, -1, 8'h00, -1, 1'b0);
            oam_cmp("oam_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sequences the OAM DMA transfer: a CPU write to the DMA register copies LENGTH bytes from (src_hi<<8) to DST_BASE.
- Sits between the CPU and the shared memory bus (cartridge/WRAM/VRAM/OAM memories with posedge write and negedge read).
- Owns the bus while a transfer is active and blocks CPU bus access for that time.
- HRAM (FF80–FFFE) is wired to cpu_addr directly at top level and is not routed through this block, so the CPU keeps HRAM access during DMA.

Parameters:
- REG_ADDR, 'hFF46, address of the DMA source register.
- DST_BASE, 'hFE00, first destination address (OAM).
- LENGTH, 160, bytes per transfer.
- CNTBITS, 8, width of the byte counter; must satisfy 2^CNTBITS > LENGTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address.
- cpu_data_w  in  8  CPU write data.
- cpu_write_enable  in  1  CPU write strobe.
- cpu_data_r  out  8  read data returned to the CPU.
- reg_active  out  1  high when the CPU is reading REG_ADDR (write_enable low); the top-level read mux uses it.
- bus_addr  out  16  address to the shared memory bus.
- bus_data_w  out  8  write data to the bus.
- bus_write_enable  out  1  bus write strobe.
- bus_data_r  in  8  bus read data, valid at the posedge following the address.
- dma_active  out  1  high while the DMA owns the bus.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous, active-high.
- Reset values: src_reg=8'hFF, state=IDLE, counter=0, byte latch=8'h00, dma_active=0.
- States:
  - IDLE → START on a CPU write to REG_ADDR.
  - START (1 cycle) → READ.
  - READ → WRITE.
  - WRITE → READ if counter != LENGTH-1, else IDLE.
- Register write: when cpu_addr==REG_ADDR && cpu_write_enable, src_reg <= cpu_data_w at the posedge. The write is accepted in any state.
- Restart: a register write while not IDLE restarts the transfer. Next state is START, counter=0, and the new src_reg is used.
- Effective source page: src_page = src_reg if src_reg < 8'hE0, else src_reg - 8'h20. This maps echo/OAM/IO pages down into WRAM.
- READ cycle outputs: bus_addr = {src_page, counter}, bus_write_enable=0. At the ending posedge, latch <= bus_data_r.
- WRITE cycle outputs: bus_addr = DST_BASE + counter, bus_data_w = latch, bus_write_enable=1. At the ending posedge, counter increments, or clears to 0 on the last byte.
- Transfer timing: trigger write captured at posedge P. dma_active is high from the cycle after P through the last WRITE cycle, i.e. 1 + 2*LENGTH = 321 cycles. It is low in the cycle after the last WRITE.
- Bus mux when IDLE: bus_addr=cpu_addr, bus_data_w=cpu_data_w, bus_write_enable = cpu_write_enable && cpu_addr!=REG_ADDR.
- Bus mux when not IDLE: the bus is driven by the DMA only. CPU writes to non-REG_ADDR addresses are dropped.
- cpu_data_r when cpu_addr==REG_ADDR: src_reg, in any state.
- cpu_data_r otherwise: bus_data_r when IDLE, 8'hFF when not IDLE.
- reg_active = (cpu_addr==REG_ADDR) && !cpu_write_enable.
- All outputs except cpu_data_r and reg_active are registered or derived only from state, counter and latch (no CPU-to-bus path while active).
- Reset mid-transfer: the next cycle is IDLE, dma_active=0, and the bus returns to the CPU. Partially written OAM is left as is.
- A register write in the same cycle as reset: reset wins.

Test Plan:
- Reset, CPU reads FF46 → cpu_data_r=8'hFF, reg_active=1, dma_active=0, bus follows CPU.
- Preload C000..C09F with i^8'h5A; write 8'hC0 to FF46 → dma_active high for exactly 321 cycles; FE00..FE9F hold i^8'h5A; bus_addr order C000, FE00, C001, FE01, ….
- During the DMA, CPU writes 8'h12 to C100 and reads 8000 → C100 unchanged, read returns 8'hFF. CPU reads FF46 → returns 8'hC0.
- Write 8'hFE to FF46 → source reads come from DE00..DE9F. Write 8'hDF → DF00..DF9F with no remap.
- Write 8'hC0 to FF46, then 8'hD0 at cycle 50 → the transfer restarts from D000 at counter 0. OAM ends with D000.. data, and dma_active lasts 321 cycles after the second write.
- Assert reset at cycle 100 of a transfer → dma_active=0 the next cycle, FF46 reads 8'hFF, and a subsequent CPU write to FE00 reaches the bus.
